md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
// - Sequences the multiply/divide unit and owns the HI/LO registers. Sits in the E stage beside the ALU.
// - Accepts mult/multu/div/divu starts and mthi/mtlo writes from the ID/EX carrier outputs.
// - Models the unit's multi-cycle latency and generates the decode-stage stall for md-using instructions.
// PARAMETERS
// - MUL_CYCLES  5   cycles from mult start to HI/LO commit (range 1..15)
// - DIV_CYCLES  10  cycles from div start to HI/LO commit (range 1..15)
// PORTS
// - clk        in   1   system clock, single clock domain
// - reset      in   1   synchronous, active-high
// - StartE     in   1   E-stage mult/div start
// - MDE        in   1   0 = multiply, 1 = divide
// - MDSignE    in   1   1 = signed operation
// - HLWriteE   in   1   mthi/mtlo write
// - HLSelE     in   1   HLWriteE target: 1 = HI, 0 = LO
// - MulFlushE  in   1   exception flush; suppresses a start or HL write in the same cycle
// - SrcAE      in   32  rs operand (also the mthi/mtlo data)
// - SrcBE      in   32  rt operand
// - MDUseD     in   1   D-stage instruction uses the md unit (mult/div/mf*/mt*)
// - BusyE      out  1   operation in flight
// - StallD     out  1   stall F/D and flush E
// - DoneE      out  1   one-cycle pulse in the cycle HI/LO commit
// - HI         out  32  HI register
// - LO         out  32  LO register
// BEHAVIOUR
// - Reset values: HI=0, LO=0, BusyE=0, DoneE=0, state IDLE, count=0, pending results=0.
//   Reset mid-operation aborts the operation; no commit.
// - States: IDLE, BUSY.
// - Start qualification: go = StartE & ~MulFlushE.
// - IDLE -> BUSY on go:
//   - Latch the 64-bit pending result, computed from SrcAE/SrcBE at the start edge.
//   - count <= MDE ? DIV_CYCLES : MUL_CYCLES.
// - BUSY: count decrements every cycle. On the edge where count==1: HI/LO <= pending, DoneE=1 for the next cycle, state -> IDLE.
// - Timing: BusyE is high for exactly N cycles, starting the cycle after go, where N = MUL_CYCLES or DIV_CYCLES.
//   HI/LO show the new value in the cycle after the last busy cycle.
// - Multiply results:
//   - mult: {HI,LO} = signed 32x32 -> 64-bit product.
//   - multu: unsigned product.
// - Divide results:
//   - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
//   - divu: unsigned quotient and remainder.
//   - Divide by zero: full latency still runs; HI/LO are left unchanged at commit.
// - HL write (HLWriteE & ~MulFlushE):
//   - In IDLE: the selected register <= SrcAE at the edge; the other register holds.
//   - In BUSY: the write aborts the operation (state -> IDLE, no commit, no DoneE) and then performs the write.
//     StallD normally prevents this case.
// - StartE while BUSY: ignored; StallD normally prevents it.
// - StallD = MDUseD & (BusyE | go). Combinational. A D-stage md user waits until the commit cycle has passed.
// - StartE with MulFlushE: no state change. An op already in BUSY is not cancelled by MulFlushE.
// - A same-cycle go and HLWriteE cannot both occur (one instruction in E); if both are asserted, the start wins.
// TESTING
// - mult 3 x 0xFFFFFFFE (signed) -> BusyE high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; DoneE pulses once.
// - divu 7 / 2 -> BusyE high 10 cycles; then LO=0x00000003, HI=0x00000001.
// - div 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
// - div by 0 with HI=0x11, LO=0x22 -> after 10 cycles HI=0x11, LO=0x22 unchanged.
// - MDUseD held from the start cycle -> StallD=1 during the start cycle plus 5 busy cycles (mult), 0 once IDLE.
// - StartE with MulFlushE=1 -> BusyE stays 0, HI/LO unchanged.
// - Reset asserted at busy cycle 3 -> BusyE=0 next cycle; HI=LO=0; no DoneE.
// - mtlo 0xABCD in IDLE -> LO=0xABCD next cycle, HI unchanged.

Source files
------------

// File: rtl/md_sequencer_if.sv
// E-stage multiply/divide bundle: operand/control inputs from ID/EX and
// the busy/stall/result outputs back to the pipeline.
interface md_sequencer_if;
    logic        StartE;
    logic        MDE;
    logic        MDSignE;
    logic        HLWriteE;
    logic        HLSelE;
    logic        MulFlushE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        MDUseD;
    logic        BusyE;
    logic        StallD;
    logic        DoneE;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output StartE, MDE, MDSignE, HLWriteE, HLSelE, MulFlushE,
               SrcAE, SrcBE, MDUseD,
        input  BusyE, StallD, DoneE, HI, LO
    );

    modport slave (
        input  StartE, MDE, MDSignE, HLWriteE, HLSelE, MulFlushE,
               SrcAE, SrcBE, MDUseD,
        output BusyE, StallD, DoneE, HI, LO
    );
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, models the unit's fixed latency
// and raises the decode-stage stall for instructions that touch the unit.
module md_sequencer #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input logic            clk,
    input logic            reset,
    md_sequencer_if.slave  md
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [63:0] pending;
    logic        commit_ok;
    logic        done;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        go;
    logic        hl_wr;
    logic signed [63:0] a64;
    logic signed [63:0] b64;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] result;
    logic        div_zero;

    assign go    = md.StartE & ~md.MulFlushE;
    assign hl_wr = md.HLWriteE & ~md.MulFlushE;

    // Operands widened past 32 bits so signed and unsigned forms share one
    // datapath, and INT_MIN / -1 cannot overflow the divider.
    always_comb begin
        a64      = {{32{md.MDSignE & md.SrcAE[31]}}, md.SrcAE};
        b64      = {{32{md.MDSignE & md.SrcBE[31]}}, md.SrcBE};
        div_zero = (md.SrcBE == 32'd0);
        prod     = a64 * b64;
        quot     = '0;
        rem      = '0;
        if (!div_zero) begin
            quot = 32'(a64 / b64);
            rem  = 32'(a64 % b64);
        end
        result = md.MDE ? {rem, quot} : prod;
    end

    // NOTE: reset is synchronous here, so it lives inside the clocked block
    // and every state element, including the pending result, is cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            pending   <= '0;
            commit_ok <= 1'b0;
            done      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        pending   <= result;
                        commit_ok <= ~(md.MDE & div_zero);
                        count     <= md.MDE ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
                        state     <= BUSY;
                    end else if (hl_wr) begin
                        if (md.HLSelE) hi_q <= md.SrcAE;
                        else           lo_q <= md.SrcAE;
                    end
                end
                BUSY: begin
                    if (hl_wr) begin
                        // An HL write in flight abandons the operation.
                        state <= IDLE;
                        count <= '0;
                        if (md.HLSelE) hi_q <= md.SrcAE;
                        else           lo_q <= md.SrcAE;
                    end else begin
                        count <= count - 4'd1;
                        if (count == 4'd1) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            if (commit_ok) begin
                                hi_q <= pending[63:32];
                                lo_q <= pending[31:0];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.BusyE  = (state == BUSY);
    assign md.StallD = md.MDUseD & (md.BusyE | go);
    assign md.DoneE  = done;
    assign md.HI     = hi_q;
    assign md.LO     = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed and random checks of md_sequencer against an arithmetic model
// of HI/LO and the fixed busy latency.
module tb_md_sequencer;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    md_sequencer_if mif ();

    md_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mif.StartE    = 1'b0;
        mif.MDE       = 1'b0;
        mif.MDSignE   = 1'b0;
        mif.HLWriteE  = 1'b0;
        mif.HLSelE    = 1'b0;
        mif.MulFlushE = 1'b0;
        mif.SrcAE     = '0;
        mif.SrcBE     = '0;
        mif.MDUseD    = 1'b0;
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    task automatic model_op(input bit is_div, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (!is_div) begin
            p        = 64'(sa * sb);
            model_hi = p[63:32];
            model_lo = p[31:0];
        end else if (b != 32'd0) begin
            q        = sa / sb;
            r        = sa % sb;
            model_lo = 32'(q);
            model_hi = 32'(r);
        end
    endtask

    task automatic run_op(input string tag, input bit is_div, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b, input bit use_d);
        int busy_cnt;
        int n;
        n = is_div ? DIV_N : MUL_N;
        @(negedge clk);
        mif.StartE = 1'b1; mif.MDE = is_div; mif.MDSignE = sgn;
        mif.SrcAE = a; mif.SrcBE = b; mif.MDUseD = use_d;
        #1;
        if (use_d) check({tag, "_stall_start"}, 64'(mif.StallD), 64'd1);
        model_op(is_div, sgn, a, b);
        @(negedge clk);
        mif.StartE = 1'b0;
        #1;
        busy_cnt = 0;
        for (int i = 0; i < 40 && mif.BusyE; i++) begin
            busy_cnt++;
            if (use_d && !mif.StallD) check({tag, "_stall_busy"}, 64'(mif.StallD), 64'd1);
            if (mif.DoneE) check({tag, "_done_early"}, 64'(mif.DoneE), 64'd0);
            @(negedge clk);
            #1;
        end
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
        check({tag, "_done"}, 64'(mif.DoneE), 64'd1);
        check({tag, "_hi"}, 64'(mif.HI), 64'(model_hi));
        check({tag, "_lo"}, 64'(mif.LO), 64'(model_lo));
        if (use_d) check({tag, "_stall_idle"}, 64'(mif.StallD), 64'd0);
        mif.MDUseD = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(mif.DoneE), 64'd0);
    endtask

    task automatic hl_write(input string tag, input bit sel, input logic [31:0] data);
        @(negedge clk);
        mif.HLWriteE = 1'b1; mif.HLSelE = sel; mif.SrcAE = data;
        @(negedge clk);
        mif.HLWriteE = 1'b0;
        #1;
        if (sel) model_hi = data;
        else     model_lo = data;
        check({tag, "_hi"}, 64'(mif.HI), 64'(model_hi));
        check({tag, "_lo"}, 64'(mif.LO), 64'(model_lo));
    endtask

    initial begin
        bit          rd, rs;
        logic [31:0] ra, rb;
        int          seen_done;

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mif.MDUseD = 1'b1;
        #1;
        model_hi = '0;
        model_lo = '0;
        check("reset_hi", 64'(mif.HI), 64'd0);
        check("reset_lo", 64'(mif.LO), 64'd0);
        check("reset_busy", 64'(mif.BusyE), 64'd0);
        check("reset_done", 64'(mif.DoneE), 64'd0);
        check("reset_stall", 64'(mif.StallD), 64'd0);
        mif.MDUseD = 1'b0;

        run_op("mult_neg", 1'b0, 1'b1, 32'd3, 32'hFFFF_FFFE, 1'b1);
        check("mult_neg_hi_const", 64'(mif.HI), 64'h0000_0000_FFFF_FFFF);
        check("mult_neg_lo_const", 64'(mif.LO), 64'h0000_0000_FFFF_FFFA);

        run_op("divu_7_2", 1'b1, 1'b0, 32'd7, 32'd2, 1'b0);
        check("divu_lo_const", 64'(mif.LO), 64'd3);
        check("divu_hi_const", 64'(mif.HI), 64'd1);

        run_op("div_neg", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg_lo_const", 64'(mif.LO), 64'h0000_0000_FFFF_FFFD);
        check("div_neg_hi_const", 64'(mif.HI), 64'h0000_0000_FFFF_FFFF);

        hl_write("mthi", 1'b1, 32'h11);
        hl_write("mtlo", 1'b0, 32'h22);
        run_op("div_zero", 1'b1, 1'b1, 32'h1234, 32'd0, 1'b0);
        check("div_zero_hi_const", 64'(mif.HI), 64'h11);
        check("div_zero_lo_const", 64'(mif.LO), 64'h22);

        run_op("div_min_m1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("multu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Flushed start must leave the unit idle.
        @(negedge clk);
        mif.StartE = 1'b1; mif.MulFlushE = 1'b1; mif.MDUseD = 1'b1;
        mif.SrcAE = 32'd9; mif.SrcBE = 32'd9;
        #1;
        check("flush_stall", 64'(mif.StallD), 64'd0);
        @(negedge clk);
        mif.StartE = 1'b0; mif.MulFlushE = 1'b0; mif.MDUseD = 1'b0;
        #1;
        check("flush_busy", 64'(mif.BusyE), 64'd0);
        check("flush_hi", 64'(mif.HI), 64'(model_hi));
        check("flush_lo", 64'(mif.LO), 64'(model_lo));

        hl_write("mtlo_abcd", 1'b0, 32'h0000_ABCD);

        // Reset during the third busy cycle aborts without a commit.
        @(negedge clk);
        mif.StartE = 1'b1; mif.MDE = 1'b0; mif.MDSignE = 1'b0;
        mif.SrcAE = 32'd6; mif.SrcBE = 32'd7;
        @(negedge clk);
        mif.StartE = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mid_busy3", 64'(mif.BusyE), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_hi = '0;
        model_lo = '0;
        check("rst_mid_busy", 64'(mif.BusyE), 64'd0);
        check("rst_mid_hi", 64'(mif.HI), 64'd0);
        check("rst_mid_lo", 64'(mif.LO), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (mif.DoneE) seen_done++;
            @(negedge clk);
            #1;
        end
        check("rst_mid_no_done", 64'(seen_done), 64'd0);
        check("rst_mid_lo_after", 64'(mif.LO), 64'd0);

        for (int k = 0; k < 24; k++) begin
            rd = 1'($urandom_range(1));
            rs = 1'($urandom_range(1));
            ra = $urandom;
            rb = ($urandom_range(7) == 0) ? 32'd0 : $urandom >> $urandom_range(31);
            run_op("rand", rd, rs, ra, rb, 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
